mem_access_unit: RTL

Load/store front end that sits between the core's execute stage and the word-addressed data memory (1024 × 32-bit, synchronous write on regWE, combinational read). Accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake, converts byte addresses to word indices, performs read-modify-write for sub-word stores, sign/zero-extends sub-word loads, and returns results over a valid/ready response channel. Misaligned or illegal-size requests are rejected with an error response and never touch memory.

---
 rtl/mem_access_unit.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Load/store front end between the execute stage and a
//             word-addressed data memory (combinational read, synchronous
//             write). Turns byte-addressed byte/half/word requests into
//             word accesses, does read-modify-write for sub-word stores,
//             sign/zero-extends sub-word loads and reports misaligned or
//             illegal-size requests without touching memory.
//
//  Ports    : clk, rst_n            clock, synchronous active-low reset
//             req_valid/req_ready   request handshake (ready only when idle)
//             req_we                1 = store, 0 = load
//             req_size              0 byte, 1 half, 2 word, 3 illegal
//             req_signed            load extension select
//             req_addr              byte address
//             req_wdata             right-justified store data
//             resp_valid/resp_ready response handshake
//             resp_rdata            extended load data (0 for stores/errors)
//             resp_err              misaligned or illegal-size request
//             mem_addr/mem_we       word index / write enable to memory
//             mem_wdata/mem_rdata   memory write / read data
//
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,

    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;
    localparam logic [1:0] c_SIZE_BAD  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Request fields captured at accept time.
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_lane;
    logic [15:0]       r_wdata;     // only the low half is ever merged
    logic [ADDR_W-3:0] r_wordIdx;

    // Memory write word and response payload registers.
    logic [31:0]       r_memWdata;
    logic [31:0]       r_respData;
    logic              r_respErr;

    logic              w_reqErr;
    logic              w_wordStore;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_loadData;
    logic [31:0]       w_mergeWord;

    // ------------------------------------------------------------------------
    // Request decode: alignment / size legality of the incoming request.
    // ------------------------------------------------------------------------
    always_comb begin
        w_reqErr = 1'b0;
        case (req_size)
            c_SIZE_BYTE: w_reqErr = 1'b0;
            c_SIZE_HALF: w_reqErr = req_addr[0];
            c_SIZE_WORD: w_reqErr = (req_addr[1:0] != 2'b00);
            c_SIZE_BAD:  w_reqErr = 1'b1;
            default:     w_reqErr = 1'b1;
        endcase
    end

    // A full-word store needs no read, so it skips READ entirely.
    assign w_wordStore = req_we && (req_size == c_SIZE_WORD);

    // ------------------------------------------------------------------------
    // Load extraction from the word currently presented by the memory.
    // ------------------------------------------------------------------------
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase

        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (r_size)
            c_SIZE_BYTE: w_loadData = {{24{r_signed & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_loadData = {{16{r_signed & w_half[15]}}, w_half};
            default:     w_loadData = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sub-word store merge: keep the read word, replace only target lanes.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mergeWord = mem_rdata;
        if (r_size == c_SIZE_BYTE) begin
            case (r_lane)
                2'd0:    w_mergeWord[7:0]   = r_wdata[7:0];
                2'd1:    w_mergeWord[15:8]  = r_wdata[7:0];
                2'd2:    w_mergeWord[23:16] = r_wdata[7:0];
                2'd3:    w_mergeWord[31:24] = r_wdata[7:0];
                default: w_mergeWord[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_size == c_SIZE_HALF) begin
            if (r_lane[1]) begin
                w_mergeWord[31:16] = r_wdata;
            end else begin
                w_mergeWord[15:0]  = r_wdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and control outputs.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_we      = 1'b0;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_reqErr) begin
                        w_nextState = S_RESP;
                    end else if (w_wordStore) begin
                        w_nextState = S_WRITE;
                    end else begin
                        w_nextState = S_READ;
                    end
                end
            end
            S_READ: begin
                w_nextState = r_we ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                // Memory commits mem_wdata at the edge that leaves this state,
                // so a write that reaches WRITE always completes.
                mem_we      = 1'b1;
                w_nextState = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_signed   <= 1'b0;
            r_lane     <= 2'd0;
            r_wdata    <= 16'd0;
            r_wordIdx  <= '0;
            r_memWdata <= 32'd0;
            r_respData <= 32'd0;
            r_respErr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata[15:0];
                        r_wordIdx  <= req_addr[ADDR_W-1:2];
                        // Stores and errors return zero data; loads
                        // overwrite this when the word is read.
                        r_respData <= 32'd0;
                        r_respErr  <= w_reqErr;
                        if (!w_reqErr && w_wordStore) begin
                            r_memWdata <= req_wdata;
                        end
                    end
                end
                S_READ: begin
                    if (r_we) begin
                        r_memWdata <= w_mergeWord;
                    end else begin
                        r_respData <= w_loadData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr   = r_wordIdx;
    assign mem_wdata  = r_memWdata;
    assign resp_rdata = r_respData;
    assign resp_err   = r_respErr;

endmodule
`default_nettype wire
